register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_read_port.sv | 56 +++++
 rtl/register_file.sv | 93 +++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared processor constants for the general-purpose register file: default
// data/index widths, the resulting register count and the hard-wired zero
// register index.
// -----------------------------------------------------------------------------
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int REG_ZERO   = 0;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file. Applies the zero-register
// rule (index 0 always reads 0) and, when WRITE_THROUGH=1, forwards the data
// being written this cycle to a matching read index.
//
// Ports:
//   addr     in   ADDR_WIDTH  read index
//   stored   in   DATA_WIDTH  array contents at addr (selected by the parent)
//   wr_en    in   1           write enable of the write port
//   wr_addr  in   ADDR_WIDTH  write index
//   wr_data  in   DATA_WIDTH  write data
//   rd_data  out  DATA_WIDTH  read result
// -----------------------------------------------------------------------------
module regfile_read_port #(
    parameter int DATA_WIDTH    = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH    = register_file_pkg::ADDR_WIDTH,
    parameter bit WRITE_THROUGH = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] stored,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);
    import register_file_pkg::*;

    logic is_zero;
    assign is_zero = (addr == ADDR_WIDTH'(REG_ZERO));

    if (WRITE_THROUGH) begin : g_forward
        logic fwd_hit;
        // A write to register 0 is dropped, so it must never be forwarded.
        assign fwd_hit = wr_en && (wr_addr != ADDR_WIDTH'(REG_ZERO)) && (addr == wr_addr);

        // NOTE: rd_data gets a default before any condition so every path
        // assigns it and no latch is inferred.
        always_comb begin
            rd_data = stored;
            if (fwd_hit) rd_data = wr_data;
            if (is_zero) rd_data = '0;
        end
    end else begin : g_no_forward
        // The write port is deliberately left out of the read path here so the
        // single-cycle datapath has no WR_DATA -> read -> ALU loop.
        logic unused_wr_port;
        assign unused_wr_port = ^{wr_en, wr_addr, wr_data};

        always_comb begin
            rd_data = stored;
            if (is_zero) rd_data = '0;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file with one write
// port, two combinational operand read ports and a combinational debug read
// port. Register 0 is hard-wired to zero. Optional write-through forwarding.
//
// Ports:
//   CLK        in   1           rising-edge clock
//   RST        in   1           synchronous active-high reset (clears all)
//   RD_ADDR_1  in   ADDR_WIDTH  read port 1 index (rs)
//   RD_ADDR_2  in   ADDR_WIDTH  read port 2 index (rt)
//   WR_ADDR    in   ADDR_WIDTH  write index
//   WR_DATA    in   DATA_WIDTH  write-back data
//   WR_EN      in   1           write enable
//   DBG_ADDR   in   ADDR_WIDTH  debug read index
//   RD_DATA_1  out  DATA_WIDTH  read port 1 data
//   RD_DATA_2  out  DATA_WIDTH  read port 2 data
//   DBG_DATA   out  DATA_WIDTH  debug read data
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH    = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH    = register_file_pkg::ADDR_WIDTH,
    parameter bit WRITE_THROUGH = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR_1,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR_2,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
    output logic [DATA_WIDTH-1:0] RD_DATA_1,
    output logic [DATA_WIDTH-1:0] RD_DATA_2,
    output logic [DATA_WIDTH-1:0] DBG_DATA
);
    import register_file_pkg::*;

    localparam int REG_COUNT = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // NOTE: the array is cleared by reset, so it maps to flops rather than a
    // RAM macro; that is required because every register must read 0 after it.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (WR_EN && (WR_ADDR != ADDR_WIDTH'(REG_ZERO))) begin
            regs[WR_ADDR] <= WR_DATA;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WRITE_THROUGH(WRITE_THROUGH)
    ) u_port_1 (
        .addr   (RD_ADDR_1),
        .stored (regs[RD_ADDR_1]),
        .wr_en  (WR_EN),
        .wr_addr(WR_ADDR),
        .wr_data(WR_DATA),
        .rd_data(RD_DATA_1)
    );

    regfile_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WRITE_THROUGH(WRITE_THROUGH)
    ) u_port_2 (
        .addr   (RD_ADDR_2),
        .stored (regs[RD_ADDR_2]),
        .wr_en  (WR_EN),
        .wr_addr(WR_ADDR),
        .wr_data(WR_DATA),
        .rd_data(RD_DATA_2)
    );

    regfile_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WRITE_THROUGH(WRITE_THROUGH)
    ) u_port_dbg (
        .addr   (DBG_ADDR),
        .stored (regs[DBG_ADDR]),
        .wr_en  (WR_EN),
        .wr_addr(WR_ADDR),
        .wr_data(WR_DATA),
        .rd_data(DBG_DATA)
    );

endmodule : register_file
